// File: rtl/fifo_uart_tx.sv
// Drains bytes from an upstream FIFO and sends each one as an 8N1 UART frame.
// One pop per frame. The serial line idles high.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  // state  | meaning
  // IDLE   | line high; waits for en=1 with a non-empty FIFO
  // POP    | one-cycle read strobe to the FIFO
  // LOAD   | capture fifo_dout and clear the baud counter
  // START  | start bit (low)
  // DATA   | eight data bits, LSB first
  // STOP   | stop bit (high); tx_done on its final cycle
  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             tx_n;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shreg_n    = shreg;
    fifo_rd_en = 1'b0;
    tx_done    = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (en && !fifo_empty) state_n = S_POP;
      end
      S_POP: begin
        fifo_rd_en = 1'b1;
        state_n    = S_LOAD;
      end
      S_LOAD: begin
        shreg_n = fifo_dout;
        cnt_n   = '0;
        idx_n   = 3'd0;
        state_n = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) state_n = S_STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          tx_done = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // tx is computed from the next state, so the line flop changes together with the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shreg_n[idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shreg <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      tx    <= tx_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx with CLKS_PER_BIT=4. It models the upstream FIFO with a queue.
// Frame tables, hand-written corner sequences, and random byte bursts are checked against a timeline model.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int FRAME_CYC = 43;  // pop, load, 40 bit cycles, one idle gap

  logic       clk = 1'b0;
  logic       rst, en, fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en, tx, busy, tx_done;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [7:0] q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // expected serial bits, line[0] sent first
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock. Outputs are sampled 1 time unit after the edge.
  task automatic step();
    logic rd;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd) begin
      pops++;
      if (q.size() > 0) fifo_dout = q.pop_front();
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic check_frame(input logic [9:0] line, input string tag, input bit drop_en,
                             output int waited);
    logic [3:0] seen;
    logic [3:0] dvec;
    int dones;
    int busy_cnt;
    waited = 0;
    do begin
      step();
      waited++;
    end while (fifo_rd_en !== 1'b1 && waited < 60);
    if (fifo_rd_en !== 1'b1) begin
      chk({tag, "_pop_timeout"}, 32'(fifo_rd_en), 1);
      return;
    end
    chk({tag, "_pop_busy"}, 32'(busy), 1);
    step();
    chk({tag, "_load"}, {tx, busy, fifo_rd_en, tx_done}, 4'b1100);
    dones = 0;
    busy_cnt = 0;
    dvec = '0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < CPB; k++) begin
        if (drop_en && i == 3 && k == 0) en = 1'b0;
        step();
        seen[k] = tx;
        if (busy === 1'b1) busy_cnt++;
        if (tx_done === 1'b1) dones++;
        if (i == 9) dvec[k] = tx_done;
        if (fifo_rd_en !== 1'b0) chk({tag, "_extra_pop"}, 32'(fifo_rd_en), 0);
      end
      chk($sformatf("%s_bit%0d", tag, i), seen, {4{line[i]}});
    end
    chk({tag, "_busy_cycles"}, busy_cnt, 40);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_done_pos"}, dvec, 4'b1000);
    step();
    chk({tag, "_gap"}, {tx, busy, tx_done}, 3'b100);
  endtask

  vec_t tbl[6];
  int w;
  int errs;
  int p0;
  int n;
  logic [7:0] rb[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 10'h34A};
    tbl[1] = '{8'h00, 10'h200};
    tbl[2] = '{8'hFF, 10'h3FE};
    tbl[3] = '{8'h3C, 10'h278};
    tbl[4] = '{8'h01, 10'h202};
    tbl[5] = '{8'h80, 10'h300};

    rst = 1'b0; en = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    @(posedge clk); #1;
    step(); step();
    chk("reset_state", {tx, busy, fifo_rd_en, tx_done}, 4'b1000);
    rst = 1'b1;

    // Empty FIFO with en held high: nothing happens.
    en = 1'b1;
    errs = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if ({tx, busy, fifo_rd_en} !== 3'b100) errs++;
    end
    chk("empty_idle_errs", errs, 0);
    chk("empty_no_pops", pops, 0);

    // Single frames from the table.
    foreach (tbl[i]) begin
      push(tbl[i].data);
      check_frame(tbl[i].line, $sformatf("tbl%0d", i), 1'b0, w);
      chk($sformatf("tbl%0d_latency", i), w, 1);
    end

    // Back-to-back frames with a single idle cycle between them.
    p0 = pops;
    push(8'h00); push(8'hFF);
    check_frame(10'h200, "b2b0", 1'b0, w);
    check_frame(10'h3FE, "b2b1", 1'b0, w);
    chk("b2b_gap", w, 1);
    for (int c = 0; c < 5; c++) step();
    chk("b2b_pops", pops - p0, 2);

    // Dropping en mid-frame finishes the frame and blocks the next pop.
    p0 = pops;
    push(8'h3C); push(8'h5A);
    check_frame(10'h278, "gate", 1'b1, w);
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) errs++;
    end
    chk("gate_hold_errs", errs, 0);
    chk("gate_pops", pops - p0, 1);
    en = 1'b1;
    check_frame(10'h2B4, "resume", 1'b0, w);
    chk("resume_latency", w, 1);

    // Reset in the middle of data bit 3 of 0x96.
    push(8'h96);
    w = 0;
    do begin step(); w++; end while (fifo_rd_en !== 1'b1 && w < 60);
    chk("rst_pop_seen", 32'(fifo_rd_en), 1);
    step();                                   // load
    for (int c = 0; c < CPB * 4 + 1; c++) step();  // start + bits 0..2 + first cycle of bit 3
    chk("rst_pre_tx", {tx, busy}, 2'b01);
    rst = 1'b0;
    step();
    chk("rst_abort", {tx, busy, fifo_rd_en, tx_done}, 4'b1000);
    step();
    chk("rst_hold", {tx, busy, fifo_rd_en, tx_done}, 4'b1000);
    push(8'hC3);
    rst = 1'b1;
    check_frame(10'h386, "post_rst", 1'b0, w);
    chk("post_rst_latency", w, 1);

    // Random bursts compared cycle by cycle against a frame-timeline model.
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        rb[j] = 8'($urandom);
        push(rb[j]);
      end
      for (int c = 1; c <= n * FRAME_CYC + 5; c++) begin
        int f, o, b;
        logic bv;
        logic [3:0] exp;
        f = (c - 1) / FRAME_CYC;
        o = (c - 1) % FRAME_CYC;
        step();
        if (f >= n || o == FRAME_CYC - 1) exp = 4'b1000;
        else if (o == 0) exp = 4'b1110;
        else if (o == 1) exp = 4'b1100;
        else begin
          b = (o - 2) / CPB;
          if (b == 0) bv = 1'b0;
          else if (b == 9) bv = 1'b1;
          else bv = rb[f][b-1];
          exp = {bv, 1'b1, 1'b0, (o == 41)};
        end
        chk($sformatf("rand%0d_c%0d", t, c), {tx, busy, fifo_rd_en, tx_done}, exp);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
